// File: rtl/fetch_unit.sv
// Instruction-fetch stage for the 5-stage RV32I pipeline.
// Owns the PC, keeps at most one word fetch outstanding to instruction
// memory, and hands instruction/address/valid to the IF/ID register.
// Hazard stalls freeze the delivered instruction. EX redirects flush
// everything younger than the branch, including responses still in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] instruction,
  output logic [31:0] instr_address,
  output logic        fetch_valid,
  output logic        flush_out
);

  // REQ : request presented on the memory port
  // WAIT: request accepted, response pending
  // HOLD: response captured during a stall, waiting to be delivered
  // DROP: response pending but it belongs to a flushed path
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;

  logic        accept_s;
  logic        deliver_s;
  logic [31:0] deliver_data_s;
  logic [31:0] target_s;

  // The request is never shown while reset is high, so a request cannot
  // be accepted during reset.
  assign imem_req_valid = (state_q == S_REQ) && !reset;
  assign imem_req_addr  = pc_q;
  assign accept_s       = imem_req_valid && imem_req_ready;
  assign target_s       = redirect_target & 32'hFFFF_FFFC;
  assign flush_out      = redirect_valid;

  assign instruction    = instr_q;
  assign instr_address  = addr_q;
  assign fetch_valid    = valid_q;

  // Next-state, PC and IF/ID output-register logic; redirect beats everything.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    hold_d         = hold_q;
    instr_d        = instr_q;
    addr_d         = addr_q;
    valid_d        = valid_q;
    deliver_s      = 1'b0;
    deliver_data_s = imem_resp_data;

    case (state_q)
      S_REQ: begin
        if (redirect_valid) begin
          // An accepted request is already on its way, so its response must be discarded.
          state_d = accept_s ? S_DROP : S_REQ;
        end else if (accept_s) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          state_d = imem_resp_valid ? S_REQ : S_DROP;
        end else if (imem_resp_valid) begin
          if (stall) begin
            hold_d  = imem_resp_data;
            state_d = S_HOLD;
          end else begin
            deliver_s      = 1'b1;
            deliver_data_s = imem_resp_data;
            state_d        = S_REQ;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (!stall) begin
          deliver_s      = 1'b1;
          deliver_data_s = hold_q;
          state_d        = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DROP: begin
        if (imem_resp_valid) begin
          state_d = S_REQ;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    // The PC moves only on a redirect or after its instruction is delivered.
    if (redirect_valid) begin
      pc_d = target_s;
    end else if (deliver_s) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end

    if (redirect_valid) begin
      instr_d = NOP_INSN;
      valid_d = 1'b0;
    end else if (deliver_s) begin
      instr_d = deliver_data_s;
      addr_d  = pc_q;
      valid_d = 1'b1;
    end else if (stall) begin
      instr_d = instr_q;
      valid_d = valid_q;
    end else begin
      instr_d = NOP_INSN;
      valid_d = 1'b0;
    end
  end

  // State and data registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      hold_q  <= NOP_INSN;
      instr_q <= NOP_INSN;
      addr_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. A small memory responder answers each
// accepted request with data = addr | 0x13 after a set delay. The
// expected deliveries are queued by the stimulus and checked by a
// separate monitor.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] instruction;
  logic [31:0] instr_address;
  logic        fetch_valid;
  logic        flush_out;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instruction     (instruction),
    .instr_address   (instr_address),
    .fetch_valid     (fetch_valid),
    .flush_out       (flush_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];

  // responder state
  int          resp_delay = 1;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  logic        acc = 1'b0;
  logic [31:0] acc_addr = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample acceptance before the edge, update the responder after.
  task automatic cyc();
    #1;
    acc      = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    @(posedge clk);
    @(negedge clk);
    imem_resp_valid = 1'b0;
    if (acc) begin
      pend      = 1'b1;
      pend_cnt  = resp_delay;
      pend_addr = acc_addr;
    end
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = pend_addr | 32'h0000_0013;
        pend            = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  task automatic wait_fv(input int budget, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!fetch_valid && n < budget);
    chk("wait_fetch_valid", {31'd0, fetch_valid}, 32'd1);
  endtask

  task automatic expect_insn(input logic [31:0] a);
    exp_q.push_back({a, a | 32'h0000_0013});
  endtask

  initial begin
    int n;
    reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;

    fork
      // monitor: a new delivery is fetch_valid after an edge without stall
      begin
        logic        s;
        logic [63:0] e;
        forever begin
          @(posedge clk);
          s = stall;
          @(negedge clk);
          if (fetch_valid && !s) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_delivery_addr", instr_address, 32'hDEAD_DEAD);
            end else begin
              e = exp_q.pop_front();
              chk("deliver_addr", instr_address, e[63:32]);
              chk("deliver_insn", instruction, e[31:0]);
            end
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
      end
    join_none

    // reset state
    cyc();
    cyc();
    #1;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_insn", instruction, NOP);
    chk("rst_addr", instr_address, 32'h0);
    chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
    reset = 1'b0;
    #1;
    chk("first_req_addr", imem_req_addr, 32'h0);

    // streaming: one instruction every 3 cycles
    expect_insn(32'h0);
    expect_insn(32'h4);
    wait_fv(20, n);
    chk("period_0", n, 32'd3);
    wait_fv(20, n);
    chk("period_4", n, 32'd3);

    // stall while the response for 0x8 arrives
    stall = 1'b1;
    expect_insn(32'h8);
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1;
      chk("stall_insn", instruction, 32'h17);
      chk("stall_addr", instr_address, 32'h4);
      chk("stall_fv", {31'd0, fetch_valid}, 32'd1);
      chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
    end
    stall = 1'b0;
    cyc();
    #1;
    chk("hold_fv", {31'd0, fetch_valid}, 32'd1);
    chk("hold_next_req", imem_req_addr, 32'hC);
    chk("hold_next_req_valid", {31'd0, imem_req_valid}, 32'd1);
    cyc();
    #1;
    chk("hold_no_dup", {31'd0, fetch_valid}, 32'd0);
    expect_insn(32'hC);
    wait_fv(20, n);

    // redirect in WAIT, response arrives later and is dropped
    resp_delay = 2;
    cyc();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0103;
    #1;
    chk("flush_hi", {31'd0, flush_out}, 32'd1);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("flush_lo", {31'd0, flush_out}, 32'd0);
    chk("drop_req_valid_a", {31'd0, imem_req_valid}, 32'd0);
    cyc();
    #1;
    chk("drop_req_valid_b", {31'd0, imem_req_valid}, 32'd0);
    resp_delay = 1;
    cyc();
    #1;
    chk("drop_next_req", imem_req_addr, 32'h100);
    chk("drop_next_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("drop_fv", {31'd0, fetch_valid}, 32'd0);
    expect_insn(32'h100);
    wait_fv(20, n);

    // redirect coincident with a response in WAIT
    cyc();
    cyc();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("coinc_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("coinc_req_addr", imem_req_addr, 32'h200);
    chk("coinc_fv", {31'd0, fetch_valid}, 32'd0);
    chk("coinc_insn", instruction, NOP);
    expect_insn(32'h200);
    wait_fv(20, n);

    // memory not ready for 5 cycles
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      #1;
      chk("nrdy_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("nrdy_req_addr", imem_req_addr, 32'h204);
      chk("nrdy_fv", {31'd0, fetch_valid}, 32'd0);
    end
    imem_req_ready = 1'b1;
    expect_insn(32'h204);
    wait_fv(20, n);

    // reset mid-WAIT, late response in the first cycle after reset
    cyc();
    reset = 1'b1;
    cyc();
    #1;
    chk("rst2_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst2_insn", instruction, NOP);
    chk("rst2_addr", instr_address, 32'h0);
    chk("rst2_fv", {31'd0, fetch_valid}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst2_req_addr", imem_req_addr, 32'h0);
    chk("rst2_req_valid_after", {31'd0, imem_req_valid}, 32'd1);
    expect_insn(32'h0);
    wait_fv(20, n);

    // PC wrap from 0xFFFF_FFFC; low target bits are masked
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFF;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    chk("wrap_req_valid", {31'd0, imem_req_valid}, 32'd1);
    imem_req_ready = 1'b1;
    expect_insn(32'hFFFF_FFFC);
    wait_fv(20, n);
    #1;
    chk("wrap_next_addr", imem_req_addr, 32'h0);

    // redirect on the same cycle the request is accepted
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0300;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("reqacc_drop_valid", {31'd0, imem_req_valid}, 32'd0);
    cyc();
    cyc();
    #1;
    chk("reqacc_req_addr", imem_req_addr, 32'h300);
    chk("reqacc_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("reqacc_fv", {31'd0, fetch_valid}, 32'd0);
    expect_insn(32'h300);
    wait_fv(20, n);
    cyc();
    cyc();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
